// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: PC increment and the
// queue entry layout (pc + instruction) at the default widths.
package fetch_pkg;

  localparam int PC_INC           = 4;
  localparam int FETCH_PC_BITS    = 16;
  localparam int FETCH_INSTR_BITS = 32;

  // One buffered fetch: the address it came from and the returned word.
  typedef struct packed {
    logic [FETCH_PC_BITS-1:0]    pc;
    logic [FETCH_INSTR_BITS-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush, occupancy count and a head output that is
// driven straight from the storage registers (zero when empty).
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       valid,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  // Qualify requests: never pop empty, never push full unless a pop frees a slot.
  always_comb begin
    do_pop  = pop && (cnt != '0);
    do_push = push && ((cnt != CW'(DEPTH)) || do_pop);
  end

  // Data storage; payload only, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers and occupancy; flush empties the queue in one cycle.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Head presentation: registered storage, forced to zero while empty.
  always_comb begin
    valid = (cnt != '0);
    count = cnt;
    rdata = valid ? mem[rd_ptr] : '0;
  end

endmodule

// File: rtl/fetch_prefetch.sv
// Instruction fetch stage with prefetch queue. Owns the PC, issues sequential
// word fetches with bounded outstanding requests, buffers responses and
// discards stale responses after a branch redirect.
module fetch_prefetch
  import fetch_pkg::*;
#(
  parameter int                 PC_BITS         = 16,
  parameter int                 INSTR_BITS      = 32,
  parameter int                 DEPTH           = 4,
  parameter int                 MAX_OUTSTANDING = 2,
  parameter logic [PC_BITS-1:0] RESET_PC        = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  branch_i,
  input  logic [PC_BITS-1:0]    pc_i,
  output logic                  imem_req_o,
  output logic [PC_BITS-1:0]    imem_addr_o,
  input  logic                  imem_gnt_i,
  input  logic                  imem_rvalid_i,
  input  logic [INSTR_BITS-1:0] imem_rdata_i,
  output logic                  instr_valid_o,
  output logic [INSTR_BITS-1:0] instr_o,
  output logic [PC_BITS-1:0]    pc_o,
  input  logic                  instr_ready_i
);

  localparam int CW  = $clog2(DEPTH+1);
  localparam int CW1 = CW + 1;

  typedef struct packed {
    logic [PC_BITS-1:0]    pc;
    logic [INSTR_BITS-1:0] instr;
  } entry_t;

  logic [PC_BITS-1:0] fetch_pc;
  logic [PC_BITS-1:0] resp_pc;
  logic [CW-1:0]      inflight;
  logic [CW-1:0]      drop;
  logic [CW-1:0]      count;
  logic [CW1-1:0]     credit_used;
  logic [PC_BITS-1:0] target;
  logic               issue;
  logic               push;
  logic               pop;
  entry_t             wr_entry;
  entry_t             rd_entry;
  logic               unused_pc_lsb;

  // Target alignment drops the byte offset of the branch address.
  assign unused_pc_lsb = ^pc_i[1:0];

  // Request credit, push/pop qualification and queue write data.
  always_comb begin
    credit_used = {1'b0, count} + {1'b0, inflight};
    target      = {pc_i[PC_BITS-1:2], 2'b00};
    // Every granted request must own a queue slot when its response returns.
    imem_req_o  = !rst_i && !branch_i
                  && (inflight < CW'(MAX_OUTSTANDING))
                  && (credit_used < CW1'(DEPTH));
    imem_addr_o = fetch_pc;
    issue       = imem_req_o && imem_gnt_i;
    // A response in the redirect cycle is stale regardless of drop.
    push        = imem_rvalid_i && !branch_i && (drop == '0);
    pop         = instr_valid_o && instr_ready_i && !branch_i;
    wr_entry    = '{pc: resp_pc, instr: imem_rdata_i};
  end

  // PC, in-flight credit and stale-response bookkeeping.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      inflight <= '0;
      drop     <= '0;
    end else begin
      inflight <= inflight + CW'(issue) - CW'(imem_rvalid_i);
      if (branch_i) begin
        fetch_pc <= target;
        resp_pc  <= target;
        // Everything still outstanding after this cycle's response is stale.
        drop     <= inflight - CW'(imem_rvalid_i);
      end else begin
        if (issue) begin
          fetch_pc <= fetch_pc + PC_BITS'(PC_INC);
        end
        if (imem_rvalid_i) begin
          if (drop != '0) begin
            drop <= drop - CW'(1);
          end else begin
            resp_pc <= resp_pc + PC_BITS'(PC_INC);
          end
        end
      end
    end
  end

  sync_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (push),
    .pop   (pop),
    .flush (branch_i),
    .wdata (wr_entry),
    .rdata (rd_entry),
    .valid (instr_valid_o),
    .count (count)
  );

  // Decode-facing head fields.
  always_comb begin
    instr_o = rd_entry.instr;
    pc_o    = rd_entry.pc;
  end

endmodule

// File: tb/tb_fetch_prefetch.sv
// Bench for fetch_prefetch: memory model with in-order variable latency,
// scoreboard of expected {pc, instr} pairs, a directed vector table and
// hand-written corner sequences, then a long randomised run.
module tb_fetch_prefetch;
  import fetch_pkg::*;

  localparam int          PCB   = 16;
  localparam int          IB    = 32;
  localparam int          DEPTH = 4;
  localparam int          MAXO  = 2;
  localparam logic [15:0] RPC   = 16'h0000;

  logic           clk;
  logic           rst;
  logic           branch;
  logic [PCB-1:0] pc_in;
  logic           req;
  logic [PCB-1:0] addr;
  logic           gnt;
  logic           rvalid;
  logic [IB-1:0]  rdata;
  logic           valid;
  logic [IB-1:0]  instr;
  logic [PCB-1:0] pc_out;
  logic           ready;

  fetch_prefetch #(
    .PC_BITS(PCB), .INSTR_BITS(IB), .DEPTH(DEPTH),
    .MAX_OUTSTANDING(MAXO), .RESET_PC(RPC)
  ) dut (
    .clk_i(clk), .rst_i(rst), .branch_i(branch), .pc_i(pc_in),
    .imem_req_o(req), .imem_addr_o(addr), .imem_gnt_i(gnt),
    .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
    .instr_valid_o(valid), .instr_o(instr), .pc_o(pc_out),
    .instr_ready_i(ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    int          epoch;
    int          ready_at;
  } mreq_t;

  typedef struct {
    logic        br;
    logic [15:0] tgt;
    logic        rdy;
    logic        exp_valid;
    logic [15:0] exp_pc;
  } vec_t;

  mreq_t        memq [$];
  fetch_entry_t expq [$];
  vec_t         vt [12];

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          epoch = 0;
  int          gnt_pct = 100;
  int          lat_min = 1;
  int          lat_max = 1;
  logic [15:0] exp_fetch;
  logic        cur_br;
  logic        cur_rdy;

  function automatic logic [31:0] mem_data(input logic [15:0] a);
    return {~a, a};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one cycle's inputs and compare DUT outputs against the scoreboard.
  task automatic cycle_begin(input logic br, input logic [15:0] tgt, input logic rdy);
    logic exp_req;
    cur_br  = br;
    cur_rdy = rdy;
    branch  = br;
    pc_in   = tgt;
    ready   = rdy;
    gnt     = (gnt_pct >= 100) ? 1'b1 : (int'($urandom_range(0, 99)) < gnt_pct);
    if (memq.size() != 0 && memq[0].ready_at <= cyc) begin
      rvalid = 1'b1;
      rdata  = mem_data(memq[0].addr);
    end else begin
      rvalid = 1'b0;
      rdata  = $urandom;
    end
    #1;
    exp_req = !br && (memq.size() < MAXO) && ((expq.size() + memq.size()) < DEPTH);
    chk("req", 32'(req), 32'(exp_req));
    if (req) chk("addr", 32'(addr), 32'(exp_fetch));
    chk("valid", 32'(valid), 32'(expq.size() != 0));
    if (expq.size() != 0) begin
      chk("pc", 32'(pc_out), 32'(expq[0].pc));
      chk("instr", instr, expq[0].instr);
    end
    chk("inflight_bound", 32'(memq.size() <= MAXO), 32'd1);
  endtask

  // Advance the reference model and the memory model across the clock edge.
  task automatic cycle_end();
    mreq_t        m;
    fetch_entry_t e;
    if (cur_br) begin
      expq.delete();
      epoch++;
      if (rvalid) void'(memq.pop_front());
      exp_fetch = {pc_in[15:2], 2'b00};
    end else begin
      if (cur_rdy && expq.size() != 0) void'(expq.pop_front());
      if (rvalid) begin
        m = memq.pop_front();
        if (m.epoch == epoch) begin
          e.pc    = m.addr;
          e.instr = mem_data(m.addr);
          expq.push_back(e);
        end
      end
      if (req && gnt) begin
        m.addr     = addr;
        m.epoch    = epoch;
        m.ready_at = cyc + int'($urandom_range(lat_min, lat_max));
        memq.push_back(m);
        exp_fetch = exp_fetch + 16'd4;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] head;
    bit          found;
    int          t;

    // Directed table: 1-cycle memory, always granted, then a wrapping branch.
    vt[0]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000};
    vt[1]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000};
    vt[2]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0000};
    vt[3]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0004};
    vt[4]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0008};
    vt[5]  = '{1'b1, 16'hFFFA, 1'b1, 1'b1, 16'h000C};
    vt[6]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000};
    vt[7]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000};
    vt[8]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'hFFF8};
    vt[9]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'hFFFC};
    vt[10] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0000};
    vt[11] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0004};

    rst = 1'b1; branch = 1'b0; pc_in = '0; gnt = 1'b0;
    rvalid = 1'b0; rdata = '0; ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_pc", 32'(pc_out), 32'd0);
    chk("rst_addr", 32'(addr), 32'(RPC));
    rst = 1'b0;
    exp_fetch = RPC;
    cyc = 0;

    for (int i = 0; i < 12; i++) begin
      cycle_begin(vt[i].br, vt[i].tgt, vt[i].rdy);
      chk("vec_valid", 32'(valid), 32'(vt[i].exp_valid));
      if (vt[i].exp_valid) chk("vec_pc", 32'(pc_out), 32'(vt[i].exp_pc));
      cycle_end();
    end

    // Decode stalls for 20 cycles: queue fills, requests stop, head holds.
    cycle_begin(1'b0, 16'h0, 1'b0);
    head = pc_out;
    cycle_end();
    for (int i = 0; i < 19; i++) begin
      cycle_begin(1'b0, 16'h0, 1'b0);
      chk("stall_head", 32'(pc_out), 32'(head));
      if (i == 18) begin
        chk("stall_req", 32'(req), 32'd0);
        chk("stall_fill", 32'(expq.size()), 32'(DEPTH));
      end
      cycle_end();
    end
    for (int k = 0; k < DEPTH; k++) begin
      cycle_begin(1'b0, 16'h0, 1'b1);
      chk("drain_valid", 32'(valid), 32'd1);
      chk("drain_pc", 32'(pc_out), 32'(head + 16'(4 * k)));
      cycle_end();
    end

    // Branch with two requests in flight: both stale responses discarded.
    lat_min = 2; lat_max = 2;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (memq.size() == 2) found = 1'b1;
      else begin
        cycle_begin(1'b0, 16'h0, 1'b1);
        cycle_end();
      end
    end
    chk("two_inflight_setup", 32'(found), 32'd1);
    cycle_begin(1'b1, 16'h1236, 1'b1);
    cycle_end();
    lat_min = 1; lat_max = 1;
    for (t = 1; t <= 3; t++) begin
      cycle_begin(1'b0, 16'h0, 1'b1);
      if (t < 3) chk("redirect_gap", 32'(valid), 32'd0);
      else begin
        chk("redirect_valid", 32'(valid), 32'd1);
        chk("redirect_pc", 32'(pc_out), 32'h1234);
      end
      cycle_end();
    end

    // Branch in the same cycle as a response and a pop.
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (expq.size() != 0 && memq.size() != 0 && memq[0].ready_at <= cyc) found = 1'b1;
      else begin
        cycle_begin(1'b0, 16'h0, 1'b1);
        cycle_end();
      end
    end
    chk("coincide_setup", 32'(found), 32'd1);
    cycle_begin(1'b1, 16'h2000, 1'b1);
    chk("coincide_rvalid_pop", 32'({valid, rvalid}), 32'b11);
    cycle_end();
    for (t = 1; t <= 3; t++) begin
      cycle_begin(1'b0, 16'h0, 1'b1);
      if (t == 1) chk("coincide_flush", 32'(valid), 32'd0);
      if (t == 3) chk("coincide_pc", 32'(pc_out), 32'h2000);
      cycle_end();
    end

    // Randomised grants, latencies, back-pressure and redirects.
    gnt_pct = 70; lat_min = 1; lat_max = 5;
    for (int i = 0; i < 10000; i++) begin
      cycle_begin(int'($urandom_range(0, 99)) < 3, 16'($urandom),
                  int'($urandom_range(0, 99)) < 75);
      cycle_end();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
